// File: rtl/fifo_nq_arbiter_if.sv
// Handshake bundle between enqueue requesters / queue consumer and the
// round-robin enqueue arbiter that feeds the downstream queue.
interface fifo_nq_arbiter_if #(
    parameter int REQUESTERS = 4,
    parameter int SLOTS      = 8,
    parameter int DATA_WIDTH = 32
);
    logic [REQUESTERS-1:0]            REQ_IN;
    logic [REQUESTERS*DATA_WIDTH-1:0] DATA_IN;
    logic [REQUESTERS-1:0]            GNT_OUT;
    logic                             DQ_IN;
    logic                             FLUSH_IN;
    logic                             NQ_OUT;
    logic [DATA_WIDTH-1:0]            ENQ_DATA_OUT;
    logic                             FLUSH_OUT;
    logic [$clog2(SLOTS)-1:0]         COUNT_OUT;

    modport master (
        output REQ_IN, DATA_IN, DQ_IN, FLUSH_IN,
        input  GNT_OUT, NQ_OUT, ENQ_DATA_OUT, FLUSH_OUT, COUNT_OUT
    );

    modport slave (
        input  REQ_IN, DATA_IN, DQ_IN, FLUSH_IN,
        output GNT_OUT, NQ_OUT, ENQ_DATA_OUT, FLUSH_OUT, COUNT_OUT
    );
endinterface

// File: rtl/fifo_nq_arbiter.sv
// Round-robin enqueue arbiter: picks one requester per cycle, registers its
// entry toward the queue, tracks queue occupancy and forwards flushes.
module fifo_nq_arbiter #(
    parameter ID             = "FIFO_NQ_ARBITER",
    parameter int REQUESTERS = 4,
    parameter int SLOTS      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    fifo_nq_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(REQUESTERS);
    localparam int CNT_W = $clog2(SLOTS);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(SLOTS - 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(REQUESTERS - 1);

    logic                  r_arm;
    logic [PTR_W-1:0]      r_last;
    logic [CNT_W-1:0]      r_count;
    logic                  r_nq;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_flush;

    logic                  w_full;
    logic                  w_dq_ok;
    logic [REQUESTERS-1:0] w_cand;
    logic [REQUESTERS-1:0] w_gnt;
    logic [PTR_W-1:0]      w_win;
    logic [PTR_W-1:0]      w_idx;
    logic                  w_any;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // r_arm keeps grants off until the first edge after an asynchronous release
    assign w_full  = (r_count == FULL);
    assign w_dq_ok = bus.DQ_IN && (r_count != '0);
    assign w_cand  = (bus.FLUSH_IN || w_full || !r_arm) ? '0 : bus.REQ_IN;

    always_comb begin
        w_gnt = '0;
        w_win = r_last;
        w_idx = '0;
        w_any = 1'b0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            w_idx = PTR_W'((int'(r_last) + i) % REQUESTERS);
            if (!w_any && w_cand[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
        if (w_any) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = bus.DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_arm   <= 1'b0;
            r_last  <= LAST_IDX;
            r_count <= '0;
            r_nq    <= 1'b0;
            r_data  <= '0;
            r_flush <= 1'b0;
        end else begin
            r_arm   <= 1'b1;
            r_nq    <= w_any;
            r_flush <= bus.FLUSH_IN;
            if (w_any) begin
                r_data <= w_sel_data;
                r_last <= w_win;
            end
            // Grant and dequeue in the same cycle cancel out
            if (bus.FLUSH_IN) begin
                r_count <= '0;
            end else if (w_any && !w_dq_ok) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_any && w_dq_ok) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET && bus.DQ_IN && (r_count == '0)) begin
            $info("%s underflow", ID);
        end
    end

    assign bus.GNT_OUT      = w_gnt;
    assign bus.NQ_OUT       = r_nq;
    assign bus.ENQ_DATA_OUT = r_data;
    assign bus.FLUSH_OUT    = r_flush;
    assign bus.COUNT_OUT    = r_count;
endmodule
